// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and default limits for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  localparam int BURST_MAX_DEF = 4;
  localparam int MAX_WAIT_DEF  = 8;

endpackage

// File: rtl/arb_sat_counter.sv
// 4-bit counter with synchronous clear and increment that saturates at limit_i.
module arb_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [3:0] limit_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (inc_i && (count_q < limit_i)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory: CPU priority, bounded DMA
// bursts and a starvation override. DMEM_ARB_PERF_EN adds stall/beat counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wd,
  output logic [31:0]   cpu_rd,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wd,
  output logic [31:0]   dma_rd,
  output logic          dma_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_cpu_stall,
  output logic [31:0]   perf_dma_beats
`endif
);

  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);
  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);

  logic [1:0] owner_q, owner_d;
  logic [3:0] burst_cnt_q, wait_cnt_q;
  logic       cpu_gnt, dma_sel;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_sel = 1'b0;
    if (cpu_req && dma_req) begin
      // Starvation override first, then burst continuation, else CPU priority.
      if ((wait_cnt_q == MAX_WAIT_C) ||
          ((owner_q == OWN_DMA) && (burst_cnt_q < BURST_MAX_C))) begin
        dma_sel = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req) begin
      dma_sel = 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (dma_sel) begin
      owner_d = OWN_DMA;
    end else if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end
  end

  assign mem_addr  = dma_sel ? dma_addr : cpu_addr;
  assign mem_wd    = dma_sel ? dma_wd : cpu_wd;
  assign mem_we    = dma_sel ? dma_we : (cpu_gnt & cpu_we);
  assign cpu_rd    = mem_rd;
  assign dma_rd    = mem_rd;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign dma_gnt   = dma_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Uncontended DMA beats hold the burst count rather than growing it.
  arb_sat_counter u_burst_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~dma_sel),
    .inc_i   (dma_sel & cpu_req),
    .limit_i (4'd15),
    .count_o (burst_cnt_q)
  );

  arb_sat_counter u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~(dma_req & ~dma_sel)),
    .inc_i   (dma_req & ~dma_sel),
    .limit_i (MAX_WAIT_C),
    .count_o (wait_cnt_q)
  );

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall_q, perf_dma_beats_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cpu_stall_q <= 32'd0;
      perf_dma_beats_q <= 32'd0;
    end else begin
      if (cpu_stall) perf_cpu_stall_q <= perf_cpu_stall_q + 32'd1;
      if (dma_sel)   perf_dma_beats_q <= perf_dma_beats_q + 32'd1;
    end
  end

  assign perf_cpu_stall = perf_cpu_stall_q;
  assign perf_dma_beats = perf_dma_beats_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory.
// Checks the perf counters too when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
  logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd, mem_rd;
  logic        cpu_stall, dma_gnt, mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall, perf_dma_beats;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem [256];
  logic [5:0]  t4_exp;
  logic        exp_d;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

  dmem_arbiter #(.BURST_MAX(4), .MAX_WAIT(8), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_gnt(dma_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_stall(perf_cpu_stall), .perf_dma_beats(perf_dma_beats)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80; dma_wd = 32'h0;
    rst = 1'b1;

    // Reset with both requesting: CPU wins from IDLE.
    tick();
    check("rst owner", 32'(dut.owner_q), 32'd0);
    check("rst burst", 32'(dut.burst_cnt_q), 32'd0);
    check("rst wait", 32'(dut.wait_cnt_q), 32'd0);
    check("rst cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst dma_gnt", 32'(dma_gnt), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst = 1'b0;
    tick();

    // CPU write then read-back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
    #1;
    check("cpu wr mem_we", 32'(mem_we), 32'd1);
    check("cpu wr mem_addr", mem_addr, 32'h10);
    check("cpu wr stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_we = 1'b0;
    #1;
    check("cpu rd data", cpu_rd, 32'hDEADBEEF);
    check("cpu rd mem_we", 32'(mem_we), 32'd0);
    check("cpu rd stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_req = 1'b0;

    // Uncontended DMA writes: granted every cycle, burst count never moves.
    for (int i = 0; i < 6; i++) begin
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40 + 32'(4 * i); dma_wd = 32'h1000 + 32'(i);
      #1;
      check("dma only gnt", 32'(dma_gnt), 32'd1);
      check("dma only mem_wd", mem_wd, 32'h1000 + 32'(i));
      tick();
      check("dma only burst", 32'(dut.burst_cnt_q), 32'd0);
    end
    dma_we = 1'b0; dma_addr = 32'h44;
    #1;
    check("dma rd data", dma_rd, 32'h00001001);
    tick();
    dma_req = 1'b0;
    tick();

    // DMA owns the port, then CPU joins: four contended DMA beats, then CPU.
    dma_req = 1'b1; dma_addr = 32'h48;
    #1;
    check("t4 c0 dma_gnt", 32'(dma_gnt), 32'd1);
    tick();
    t4_exp = 6'b001111;
    for (int i = 0; i < 6; i++) begin
      cpu_req = 1'b1; cpu_addr = 32'h10;
      #1;
      check("t4 dma_gnt", 32'(dma_gnt), 32'(t4_exp[i]));
      check("t4 cpu_stall", 32'(cpu_stall), 32'(t4_exp[i]));
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // Clean slate for the starvation scenario (perf counters start at zero).
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();

    // Both continuous from IDLE: 8 CPU cycles, forced DMA, burst to 4, CPU, forced again.
    for (int i = 0; i < 21; i++) begin
      cpu_req = 1'b1; dma_req = 1'b1;
      #1;
      exp_d = ((i >= 8) && (i <= 11)) || (i == 20);
      check("t5 dma_gnt", 32'(dma_gnt), 32'(exp_d));
      check("t5 cpu_stall", 32'(cpu_stall), 32'(exp_d));
      if (i == 8) check("t5 wait at force", 32'(dut.wait_cnt_q), 32'd8);
`ifdef DMEM_ARB_PERF_EN
      if (i == 20) begin
        check("perf stall", perf_cpu_stall, 32'd4);
        check("perf beats", perf_dma_beats, 32'd4);
      end
`endif
      tick();
    end
    check("t5 burst after force", 32'(dut.burst_cnt_q), 32'd1);

    // Asynchronous reset mid-burst: state clears without a clock edge.
    rst = 1'b1;
    #1;
    check("async owner", 32'(dut.owner_q), 32'd0);
    check("async burst", 32'(dut.burst_cnt_q), 32'd0);
    check("async wait", 32'(dut.wait_cnt_q), 32'd0);
    check("async dma_gnt", 32'(dma_gnt), 32'd0);
    check("async cpu_stall", 32'(cpu_stall), 32'd0);
`ifdef DMEM_ARB_PERF_EN
    check("async perf stall", perf_cpu_stall, 32'd0);
    check("async perf beats", perf_dma_beats, 32'd0);
`endif
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256-word data memory between the pipeline MEM stage (CPU port) and a DMA/loader port.
- The memory has combinational read and a write on the clock edge. The arbiter muxes address, write data and write enable one transaction per cycle.
- CPU has priority by default. DMA may hold the port for a bounded burst and is guaranteed service after a bounded wait.
- Emits a stall to the pipeline hazard unit.

Parameters:
- BURST_MAX, 4: maximum consecutive DMA grants while the CPU is requesting (1..15).
- MAX_WAIT, 8: DMA cycles denied before a forced DMA grant (1..15).
- AW, 32: address width passed through unchanged.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access this cycle.
- cpu_we  in  1  CPU write.
- cpu_addr  in  AW  CPU byte address.
- cpu_wd  in  32  CPU write data.
- cpu_rd  out  32  CPU read data.
- cpu_stall  out  1  CPU request not granted this cycle.
- dma_req  in  1  DMA access this cycle.
- dma_we  in  1  DMA write.
- dma_addr  in  AW  DMA byte address.
- dma_wd  in  32  DMA write data.
- dma_rd  out  32  DMA read data.
- dma_gnt  out  1  DMA access performed this cycle.
- mem_we  out  1  write enable to the memory.
- mem_addr  out  AW  address to the memory.
- mem_wd  out  32  write data to the memory.
- mem_rd  in  32  read data from the memory.

Behaviour:
- One clock `clk`; reset `rst` is asynchronous and active-high.
- Registered state:
  - owner_q in {IDLE, CPU, DMA}: holds the grant of the previous cycle.
  - burst_cnt (4b): consecutive DMA grants made while cpu_req was high.
  - wait_cnt (4b): consecutive cycles dma_req was high and denied.
- Reset: owner_q = IDLE, burst_cnt = 0, wait_cnt = 0. Outputs follow the combinational rules from this state.
- Grant decision is combinational from the requests and registered state; it is zero-latency within the same cycle:
  - Neither request: no grant. mem_we = 0; mem_addr and mem_wd take the CPU values.
  - Only cpu_req: grant CPU.
  - Only dma_req: grant DMA.
  - Both, wait_cnt == MAX_WAIT: grant DMA (starvation override).
  - Both, owner_q == DMA and burst_cnt < BURST_MAX: grant DMA (burst continuation).
  - Both, otherwise: grant CPU.
- Muxing:
  - mem_addr, mem_wd and mem_we = granted port's addr, wd and (we & req).
  - cpu_rd = dma_rd = mem_rd at all times; a port uses it only when granted.
- cpu_stall = cpu_req & ~cpu_grant. dma_gnt = DMA granted.
- State updates on posedge clk:
  - owner_q <= granted port, or IDLE.
  - burst_cnt: on a DMA grant with cpu_req = 1, increment and saturate at 15. On a DMA grant with cpu_req = 0, hold. On any CPU grant or idle cycle, clear to 0.
  - wait_cnt: if dma_req & ~dma_gnt, increment and saturate at MAX_WAIT. Otherwise clear to 0.
- Fairness: after a forced grant, wait_cnt = 0. With burst_cnt = 1 and owner_q = DMA, the burst may continue up to BURST_MAX total.
- Writes land on the clock edge ending the granted cycle. A read in the following cycle returns the new value.
- A denied DMA request must hold its request and payload stable until dma_gnt; the arbiter keeps no payload copy.
- Reset mid-burst: state clears immediately. The in-flight cycle's write is not guaranteed.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_cpu_stall (32b) and perf_dma_beats (32b).
  - perf_cpu_stall counts cycles with cpu_stall = 1.
  - perf_dma_beats counts cycles with dma_gnt = 1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: these ports and counters do not exist; arbitration is identical.

Decomposition:
- Shared package: owner state encoding (IDLE = 2'd0, CPU = 2'd1, DMA = 2'd2); default BURST_MAX and MAX_WAIT constants.
- One natural sub-module: arb_sat_counter, a 4-bit saturating counter with clear/inc/limit. It is instantiated for burst_cnt and wait_cnt.

Test Plan:
1. Reset: assert rst with both requests high -> owner_q = IDLE, counters 0, CPU granted, cpu_stall = 0, dma_gnt = 0.
2. CPU only: write 0xDEADBEEF at addr 0x10, then read 0x10 next cycle -> mem_we = 1 in cycle 1, cpu_rd = 0xDEADBEEF in cycle 2, cpu_stall = 0 throughout.
3. DMA only: 6 consecutive DMA writes, cpu_req = 0 -> dma_gnt = 1 every cycle, burst_cnt stays 0.
4. Both continuous, DMA starts the burst (cycle 0 DMA-only, then both high) -> dma_gnt for 4 total contended beats, then CPU granted; cpu_stall high exactly those contended cycles.
5. Both continuous from IDLE -> CPU granted 8 cycles, forced DMA grant on cycle 9 (wait_cnt == 8), burst continues to BURST_MAX, then CPU resumes.
6. With DMEM_ARB_PERF_EN: run scenario 5 for 20 cycles -> perf counters equal counted cpu_stall and dma_gnt cycles. Assert rst async mid-burst -> counters and state 0 before the next edge.
